// File: rtl/bitfield_pkg.sv
// Shared types and width-generic bit helpers for the bitfield unit.
package bitfield_pkg;

   typedef enum logic [1:0] {
      OP_ROTR = 2'd0,
      OP_ROTL = 2'd1,
      OP_INS  = 2'd2,
      OP_FSR  = 2'd3
   } bf_op_e;

   // Helpers work on a wide carrier word; callers zero-extend their operand
   // and pass the real width in w (w <= BF_MAX_W, shift amounts < w).
   localparam int unsigned BF_MAX_W = 64;
   typedef logic [BF_MAX_W-1:0] bf_word_t;

   function automatic bf_word_t bf_ones(input int unsigned w);
      return ~(~bf_word_t'(0) << w);
   endfunction

   function automatic bf_word_t rotr(input bf_word_t x, input int unsigned sh, input int unsigned w);
      return ((x >> sh) | (x << (w - sh))) & bf_ones(w);
   endfunction

   function automatic bf_word_t rotl(input bf_word_t x, input int unsigned sh, input int unsigned w);
      return ((x << sh) | (x >> (w - sh))) & bf_ones(w);
   endfunction

   function automatic bf_word_t bitrev(input bf_word_t x, input int unsigned w);
      bf_word_t r;
      r = {<<{x}};
      return r >> (BF_MAX_W - w);
   endfunction

endpackage

// File: rtl/bf_mask_gen.sv
// Stage-1 field mask selection and sign-bit index for the bitfield unit.
module bf_mask_gen
   import bitfield_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic [SHW-1:0]   maskbits,
   input  logic [SHW-1:0]   sh,
   input  bf_op_e           op,
   output logic [WIDTH-1:0] mask_sel,
   output logic [SHW-1:0]   sbit_idx
);

   logic [WIDTH-1:0] mask, mask_r, fmask;

   // Low-aligned field mask, its mirror for ROTL, and its rotation for INS.
   always_comb begin
      mask     = {WIDTH{1'b1}} >> maskbits;
      mask_r   = WIDTH'(bitrev(BF_MAX_W'(mask), WIDTH));
      fmask    = WIDTH'(rotl(BF_MAX_W'(mask), 32'(sh), WIDTH));
      mask_sel = mask;
      unique case (op)
         OP_ROTL: mask_sel = mask_r;
         OP_INS:  mask_sel = fmask;
         default: mask_sel = mask;
      endcase
      // Top bit of the surviving field; MSB when maskbits is zero.
      sbit_idx = SHW'(WIDTH - 1) - maskbits;
   end

endmodule

// File: rtl/bitfield_unit.sv
// Two-stage valid/ready rotate/shift/extract/insert unit with flush.
module bitfield_unit
   import bitfield_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int TAGW  = 5,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_sx,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [SHW-1:0]   in_sh,
   input  logic [SHW-1:0]   in_maskbits,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag
);

   // vld_pipe_q[1] = S1 occupied, vld_pipe_q[2] = S2 (output) occupied
   logic [2:1]       vld_pipe_d, vld_pipe_q;
   logic             s1_load, s2_load, in_fire;

   bf_op_e           op_d, s1_op_q;
   logic [WIDTH-1:0] rot_d, mask_d, res_d;
   logic [SHW-1:0]   sbit_idx;
   logic             sbit_d;
   logic [WIDTH-1:0] s1_rot_q, s1_mask_q, s1_b_q;
   logic             s1_sbit_q, s1_sx_q;
   logic [TAGW-1:0]  s1_tag_q;
   logic [WIDTH-1:0] out_data_q;
   logic [TAGW-1:0]  out_tag_q;

   bf_mask_gen #(.WIDTH(WIDTH)) u_mask_gen (
      .maskbits (in_maskbits),
      .sh       (in_sh),
      .op       (op_d),
      .mask_sel (mask_d),
      .sbit_idx (sbit_idx)
   );

   // Handshake: a stage loads when empty or its downstream drains; flush wins.
   always_comb begin
      s2_load    = !vld_pipe_q[2] || out_ready;
      s1_load    = !vld_pipe_q[1] || s2_load;
      in_ready   = !flush && s1_load;
      in_fire    = in_valid && in_ready;
      vld_pipe_d = vld_pipe_q;
      if (s2_load) vld_pipe_d[2] = vld_pipe_q[1];
      if (s1_load) vld_pipe_d[1] = in_fire;
      if (flush)   vld_pipe_d    = '0;
   end

   // Stage 1: rotate/funnel the source and sample the field's sign bit.
   always_comb begin
      op_d  = bf_op_e'(in_op);
      rot_d = WIDTH'(rotl(BF_MAX_W'(in_a), 32'(in_sh), WIDTH));
      unique case (op_d)
         OP_ROTR: rot_d = WIDTH'(rotr(BF_MAX_W'(in_a), 32'(in_sh), WIDTH));
         OP_FSR:  rot_d = WIDTH'({in_b, in_a} >> in_sh);
         default: rot_d = WIDTH'(rotl(BF_MAX_W'(in_a), 32'(in_sh), WIDTH));
      endcase
      sbit_d = rot_d[sbit_idx];
   end

   // Stage 2: apply mask, merge into b, or sign-extend the field.
   always_comb begin
      res_d = s1_rot_q & s1_mask_q;
      unique case (s1_op_q)
         OP_INS:          res_d = (s1_rot_q & s1_mask_q) | (s1_b_q & ~s1_mask_q);
         OP_ROTR, OP_FSR: if (s1_sx_q && s1_sbit_q) res_d = res_d | ~s1_mask_q;
         default:         res_d = s1_rot_q & s1_mask_q;
      endcase
   end

   // Valid bits clear asynchronously so in-flight work is dropped on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe_q <= '0;
      else        vld_pipe_q <= vld_pipe_d;
   end

   // Stage-1 payload; only meaningful while vld_pipe_q[1] is set.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_rot_q  <= rot_d;
         s1_mask_q <= mask_d;
         s1_sbit_q <= sbit_d;
         s1_op_q   <= op_d;
         s1_sx_q   <= in_sx;
         s1_b_q    <= in_b;
         s1_tag_q  <= in_tag;
      end
   end

   // Output registers hold while stalled and reset to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q <= '0;
         out_tag_q  <= '0;
      end else if (!flush && s2_load && vld_pipe_q[1]) begin
         out_data_q <= res_d;
         out_tag_q  <= s1_tag_q;
      end
   end

   assign out_valid = vld_pipe_q[2];
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_bitfield_unit.sv
// Self-checking bench for bitfield_unit: directed vectors, backpressure,
// flush, async reset and randomized traffic against a scoreboard model.
module tb_bitfield_unit;

   localparam int WIDTH = 32;
   localparam int TAGW  = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = '0;
   logic        in_sx = 1'b0;
   logic [31:0] in_a = '0, in_b = '0;
   logic [4:0]  in_sh = '0, in_maskbits = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   always #5 clk = ~clk;

   bitfield_unit #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sx(in_sx),
      .in_a(in_a), .in_b(in_b), .in_sh(in_sh), .in_maskbits(in_maskbits), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_out   = 0;
   logic [31:0] exp_q[$];
   logic [4:0]  tag_q[$];
   logic [31:0] cur_exp = '0;
   logic        last_acc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: rotations built from a doubled word, masks from plain shifts.
   function automatic logic [31:0] model(input logic [1:0] op, input logic sx,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [4:0] mb);
      logic [31:0] mask, mask_r, fm, rot, res;
      logic [4:0]  sb;
      mask = 32'hFFFF_FFFF >> mb;
      for (int i = 0; i < 32; i++) mask_r[i] = mask[31-i];
      fm = 32'(({mask, mask} << sh) >> 32);
      sb = 5'd31 - mb;
      case (op)
         2'd0:       rot = 32'({a, a} >> sh);
         2'd1, 2'd2: rot = 32'(({a, a} << sh) >> 32);
         default:    rot = 32'({b, a} >> sh);
      endcase
      res = rot & ((op == 2'd1) ? mask_r : mask);
      if (op == 2'd2) res = (rot & fm) | (b & ~fm);
      if ((op == 2'd0 || op == 2'd3) && sx && rot[sb]) res = res | ~mask;
      return res;
   endfunction

   task automatic set_op(input logic [1:0] op, input logic sx, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [4:0] mb,
                         input logic [4:0] tag);
      in_op = op; in_sx = sx; in_a = a; in_b = b; in_sh = sh; in_maskbits = mb; in_tag = tag;
      cur_exp = model(op, sx, a, b, sh, mb);
   endtask

   // One clock: evaluate handshakes just before the rising edge, then move to the next falling edge.
   task automatic cycle();
      #1;
      if (out_valid && out_ready) begin
         n_out++;
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q.pop_front());
            chk("out_tag", 32'(out_tag), 32'(tag_q.pop_front()));
         end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         exp_q.push_back(cur_exp);
         tag_q.push_back(in_tag);
      end
      if (flush) begin
         exp_q.delete();
         tag_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_acc(input string tag);
      in_valid = 1'b1;
      for (int k = 0; k < 32; k++) begin
         cycle();
         if (last_acc) break;
      end
      chk(tag, 32'(last_acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int k = 0; k < 64 && exp_q.size() != 0; k++) cycle();
      cycle();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic        sx;
      logic [31:0] a, b;
      logic [4:0]  sh, mb;
      logic [31:0] exp;
   } dvec_t;

   dvec_t       dv[8];
   logic [31:0] hold_d;
   logic [4:0]  hold_t;
   int          out_base;

   initial begin
      dv[0] = '{2'd0, 1'b1, 32'h8000_0000, 32'h0,         5'd4,  5'd4,  32'hF800_0000};
      dv[1] = '{2'd0, 1'b0, 32'h8000_0000, 32'h0,         5'd4,  5'd4,  32'h0800_0000};
      dv[2] = '{2'd1, 1'b0, 32'h0000_000F, 32'h0,         5'd8,  5'd8,  32'h0000_0F00};
      dv[3] = '{2'd1, 1'b0, 32'h0000_000F, 32'h0,         5'd0,  5'd0,  32'h0000_000F};
      dv[4] = '{2'd2, 1'b0, 32'h0000_00AB, 32'hFFFF_FFFF, 5'd8,  5'd24, 32'hFFFF_ABFF};
      dv[5] = '{2'd2, 1'b0, 32'h0000_00AB, 32'hFFFF_FFFF, 5'd28, 5'd24, 32'hBFFF_FFFA};
      dv[6] = '{2'd3, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8,  5'd0,  32'hF012_3456};
      dv[7] = '{2'd3, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8,  5'd24, 32'h0000_0056};

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Directed vectors with a latency check on each
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_op(dv[i].op, dv[i].sx, dv[i].a, dv[i].b, dv[i].sh, dv[i].mb, 5'(i));
         cur_exp = dv[i].exp;
         in_valid = 1'b1;
         cycle();
         in_valid = 1'b0;
         chk("lat_edge1_vld", 32'(out_valid), 32'd0);
         cycle();
         chk("lat_edge2_vld", 32'(out_valid), 32'd1);
         cycle();
      end
      drain();

      // Backpressure: 4 ops, output stalled for 3 cycles
      out_base  = n_out;
      out_ready = 1'b0;
      set_op(2'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd3, 5'd2, 5'd1);
      in_valid = 1'b1; cycle(); chk("bp_acc1", 32'(last_acc), 32'd1);
      set_op(2'd1, 1'b0, 32'h1357_9BDF, 32'h0, 5'd7, 5'd5, 5'd2);
      cycle(); chk("bp_acc2", 32'(last_acc), 32'd1);
      set_op(2'd2, 1'b0, 32'h0000_0055, 32'hA5A5_A5A5, 5'd12, 5'd20, 5'd3);
      #1;
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      hold_d = out_data;
      hold_t = out_tag;
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk("bp_hold_data", out_data, hold_d);
         chk("bp_hold_tag", 32'(out_tag), 32'(hold_t));
      end
      out_ready = 1'b1;
      wait_acc("bp_acc3");
      set_op(2'd3, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd17, 5'd9, 5'd4);
      wait_acc("bp_acc4");
      drain();
      chk("bp_out_count", 32'(n_out - out_base), 32'd4);

      // Flush with both stages full
      out_ready = 1'b0;
      set_op(2'd1, 1'b0, 32'h0000_00FF, 32'h0, 5'd4, 5'd0, 5'd9);
      wait_acc("fl_acc1");
      set_op(2'd0, 1'b0, 32'h0000_FF00, 32'h0, 5'd8, 5'd0, 5'd10);
      wait_acc("fl_acc2");
      set_op(2'd2, 1'b0, 32'h1, 32'h0, 5'd1, 5'd0, 5'd11);
      in_valid = 1'b1;
      flush = 1'b1;
      #1;
      chk("fl_in_ready", 32'(in_ready), 32'd0);
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("fl_stays_empty", 32'(out_valid), 32'd0);

      // Async reset mid-stream
      out_ready = 1'b0;
      set_op(2'd1, 1'b0, 32'h0000_000F, 32'h0, 5'd8, 5'd8, 5'd21);
      wait_acc("ar_acc1");
      set_op(2'd0, 1'b0, 32'h0000_00F0, 32'h0, 5'd4, 5'd0, 5'd22);
      wait_acc("ar_acc2");
      chk("ar_pre_valid", 32'(out_valid), 32'd1);
      chk("ar_pre_data", out_data, 32'h0000_0F00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_out_data", out_data, 32'd0);
      chk("ar_out_tag", 32'(out_tag), 32'd0);
      exp_q.delete();
      tag_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Randomized traffic with random stalls and occasional flush
      for (int k = 0; k < 600; k++) begin
         set_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         cycle();
      end
      flush = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
